// File: rtl/mips_defs_pkg.sv
// Shared MIPS EX-stage definitions: datapath width, mult/div op encodings and
// the mult/div sequencer state encoding.
package mips_defs;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider on the packed {hi,lo}
// accumulator: shift-add for multiply, restore-subtract for divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_nxt
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] trial;

   always_comb begin
      sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      // partial remainder shifted left by one, with the next dividend bit
      trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
      if (is_div)
         acc_nxt = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         acc_nxt = {sum, acc[WIDTH-1:1]};
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO
// registers; state advances on the falling clock edge.
module ex_muldiv_unit #(
   parameter int WIDTH = mips_defs::WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             stall_o,
   output logic             done_o,
   output logic             div_zero_o
);

   import mips_defs::*;

   state_e             state_q, state_nxt;
   logic [WIDTH-1:0]   opnd_q, hi_q, lo_q, a_mag, b_mag, quot, rem;
   logic [2*WIDTH-1:0] acc_q, acc_step, prod;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_q, neg_rem_q, dz_q;
   logic               a_neg, b_neg, is_div, iter, last, div_by0, fin;

   always_comb begin
      a_neg = ~op_i[0] & a_i[WIDTH-1];
      b_neg = ~op_i[0] & b_i[WIDTH-1];
      a_mag = a_neg ? -a_i : a_i;
      b_mag = b_neg ? -b_i : b_i;
   end

   assign is_div  = (state_q == ST_DIV);
   assign iter    = (state_q == ST_MUL) || is_div;
   assign last    = (cnt_q == CNT_W'(WIDTH-1));
   assign div_by0 = is_div && (opnd_q == '0);
   // the last iteration's step output is written straight into HI/LO
   assign fin     = iter && !flush_i && last && !div_by0;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc     (acc_q),
      .opnd    (opnd_q),
      .acc_nxt (acc_step)
   );

   assign prod = neg_q     ? -acc_step : acc_step;
   assign quot = neg_q     ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
   assign rem  = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: if (start_i) state_nxt = op_i[1] ? ST_DIV : ST_MUL;
         ST_MUL:  if (flush_i) state_nxt = ST_IDLE;
                  else if (last) state_nxt = ST_DONE;
         ST_DIV:  if (flush_i) state_nxt = ST_IDLE;
                  else if (div_by0 || last) state_nxt = ST_DONE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(negedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (state_q == ST_IDLE) begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
            if (start_i) begin
               opnd_q    <= op_i[1] ? b_mag : a_mag;
               acc_q     <= {{WIDTH{1'b0}}, (op_i[1] ? a_mag : b_mag)};
               cnt_q     <= '0;
               neg_q     <= a_neg ^ b_neg;
               neg_rem_q <= a_neg;
               dz_q      <= 1'b0;
            end
         end else if (iter && !flush_i) begin
            if (div_by0) begin
               dz_q <= 1'b1;
            end else begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            if (fin) begin
               if (is_div) begin
                  hi_q <= rem;
                  lo_q <= quot;
               end else begin
                  {hi_q, lo_q} <= prod;
               end
            end
         end
      end
   end

   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign busy_o     = iter;
   assign stall_o    = iter || ((state_q == ST_IDLE) && start_i);
   assign done_o     = (state_q == ST_DONE);
   assign div_zero_o = (state_q == ST_DONE) && dz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: transaction-level model compared every cycle,
// directed literal cases, then randomized traffic.
module tb_ex_muldiv_unit;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        start_i = 1'b0, flush_i = 1'b0, hi_we_i = 1'b0, lo_we_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [31:0] a_i = '0, b_i = '0, wdata_i = '0;
   logic [31:0] hi_o, lo_o;
   logic        busy_o, stall_o, done_o, div_zero_o;

   int vectors = 0;
   int miscompares = 0;

   ex_muldiv_unit dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .op_i(op_i),
      .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .hi_we_i(hi_we_i),
      .lo_we_i(lo_we_i), .wdata_i(wdata_i), .hi_o(hi_o), .lo_o(lo_o),
      .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o), .div_zero_o(div_zero_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: an accepted op's result is computed at once with plain arithmetic;
   // only a countdown of remaining busy cycles is tracked.
   int          m_left = 0;
   bit          m_done = 1'b0, m_dz = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;

   task automatic model_accept();
      longint p, q, r;
      logic [63:0] pu;
      m_dz = op_i[1] && (b_i == 0);
      case (op_i)
         2'b00: begin p = longint'($signed(a_i)) * longint'($signed(b_i)); {r_hi, r_lo} = p; end
         2'b01: begin pu = {32'b0, a_i} * {32'b0, b_i}; {r_hi, r_lo} = pu; end
         2'b10: if (!m_dz) begin
            q = longint'($signed(a_i)) / longint'($signed(b_i));
            r = longint'($signed(a_i)) % longint'($signed(b_i));
            r_lo = q[31:0];
            r_hi = r[31:0];
         end
         default: if (!m_dz) begin r_lo = a_i / b_i; r_hi = a_i % b_i; end
      endcase
      m_left = m_dz ? 1 : 32;
   endtask

   initial forever begin
      @(negedge clk_i or negedge rst_n_i);
      if (!rst_n_i) begin
         m_left = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_left > 0) begin
         if (flush_i) m_left = 0;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               if (!m_dz) begin m_hi = r_hi; m_lo = r_lo; end
            end
         end
      end else begin
         if (hi_we_i) m_hi = wdata_i;
         if (lo_we_i) m_lo = wdata_i;
         if (start_i) model_accept();
      end
   end

   initial forever begin
      @(posedge clk_i);
      chk("busy", 64'(busy_o), 64'(m_left > 0));
      chk("stall", 64'(stall_o), 64'((m_left > 0) || (!m_done && m_left == 0 && start_i)));
      chk("done", 64'(done_o), 64'(m_done));
      chk("div_zero", 64'(div_zero_o), 64'(m_done && m_dz));
      chk("hi", 64'(hi_o), 64'(m_hi));
      chk("lo", 64'(lo_o), 64'(m_lo));
   end

   task automatic step();
      @(negedge clk_i);
      #2;
   endtask

   // launch one op, optionally pulse start+MTLO at busy cycle intr, check result
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int elat, input int ebusy, input int intr);
      int cyc, nb;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      step();
      start_i = 1'b0;
      cyc = 1; nb = 0;
      while (!done_o && cyc < 100) begin
         nb += int'(busy_o);
         if (cyc == intr) begin
            start_i = 1'b1; op_i = 2'b11; a_i = 32'd9; b_i = 32'd1;
            lo_we_i = 1'b1; wdata_i = 32'hdead_beef;
         end else begin
            start_i = 1'b0; lo_we_i = 1'b0;
         end
         step();
         cyc++;
      end
      start_i = 1'b0; lo_we_i = 1'b0;
      chk("latency", 64'(cyc), 64'(elat));
      chk("busy_cycles", 64'(nb), 64'(ebusy));
      chk("op_hi", 64'(hi_o), 64'(ehi));
      chk("op_lo", 64'(lo_o), 64'(elo));
      chk("op_dz", 64'(div_zero_o), 64'(edz));
      step();
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hffff_ffff;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1;
      chk("rst_hi", 64'(hi_o), 64'h0);
      chk("rst_lo", 64'(lo_o), 64'h0);
      chk("rst_busy", 64'(busy_o), 64'h0);
      chk("rst_stall", 64'(stall_o), 64'h0);
      chk("rst_done", 64'(done_o), 64'h0);
      step();
      rst_n_i = 1'b1;
      step();

      do_op(2'b01, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001, 1'b0, 33, 32, 0);
      do_op(2'b00, 32'hffff_fffd, 32'd7, 32'hffff_ffff, 32'hffff_ffeb, 1'b0, 33, 32, 0);
      do_op(2'b10, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 1'b0, 33, 32, 0);
      do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 32, 0);
      do_op(2'b10, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, 1'b0, 33, 32, 0);

      hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h1234;
      step();
      hi_we_i = 1'b0; lo_we_i = 1'b0;
      do_op(2'b11, 32'd5, 32'd0, 32'h1234, 32'h1234, 1'b1, 2, 1, 0);

      // flush at iteration 10
      start_i = 1'b1; op_i = 2'b00; a_i = 32'd3; b_i = 32'd5;
      step();
      start_i = 1'b0;
      repeat (9) step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("flush_busy", 64'(busy_o), 64'h0);
      chk("flush_done", 64'(done_o), 64'h0);
      chk("flush_hi", 64'(hi_o), 64'h1234);
      chk("flush_lo", 64'(lo_o), 64'h1234);
      step();
      do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 32, 0);

      // start and MTLO while busy are ignored
      do_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, 32, 3);

      // reset at iteration 5
      start_i = 1'b1; op_i = 2'b01; a_i = 32'd5; b_i = 32'd7;
      step();
      start_i = 1'b0;
      repeat (4) step();
      rst_n_i = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy_o), 64'h0);
      chk("midrst_stall", 64'(stall_o), 64'h0);
      chk("midrst_done", 64'(done_o), 64'h0);
      chk("midrst_dz", 64'(div_zero_o), 64'h0);
      chk("midrst_hi", 64'(hi_o), 64'h0);
      chk("midrst_lo", 64'(lo_o), 64'h0);
      step();
      rst_n_i = 1'b1;
      step();
      do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 32, 0);

      for (int i = 0; i < 3000; i++) begin
         start_i = ($urandom_range(0, 3) == 0);
         op_i    = 2'($urandom_range(0, 3));
         a_i     = rnd_opnd();
         b_i     = rnd_opnd();
         flush_i = ($urandom_range(0, 99) == 0);
         hi_we_i = ($urandom_range(0, 7) == 0);
         lo_we_i = ($urandom_range(0, 7) == 0);
         wdata_i = $urandom;
         step();
      end
      start_i = 1'b0; flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
